// File: rtl/wishbone_master_arbiter.sv
// wishbone_master_arbiter
//   Shares one Wishbone master port of the slave interconnect between two
//   bus masters. Grants round-robin and holds a grant for a whole cyc
//   cycle. Routes read data and ack back to the granted master only, and
//   broadcasts the interrupt to both masters. A bus timeout terminates a
//   strobed transfer that never receives an ack, so a stuck slave cannot
//   lock the bus.
//
// Parameters
//   TIMEOUT  cycles a strobed transfer may wait for ack (0 disables, <= 65535)
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   m0_* / m1_*                     master-side Wishbone ports
//                                   (we/cyc/stb/sel/adr/dat in, dat/ack/int out)
//   s_we_o .. s_dat_o               muxed request toward the interconnect
//   s_dat_i, s_ack_i, s_int_i       response from the interconnect
//   timeout_o                       one-cycle pulse on a timeout termination
module wishbone_master_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_int_o,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_int_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_int_i,
  output logic        timeout_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        last;
  logic        to_ack;
  logic [15:0] cnt;
  logic        g0;
  logic        g1;
  logic        to_fire;

  assign g0 = (state == GRANT0);
  assign g1 = (state == GRANT1);

  // On a tie from IDLE the master that was not granted most recently wins.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GRANT0 : GRANT1;
        else if (m0_cyc_i)        state_nxt = GRANT0;
        else if (m1_cyc_i)        state_nxt = GRANT1;
      end
      GRANT0:  if (!m0_cyc_i) state_nxt = m1_cyc_i ? GRANT1 : IDLE;
      GRANT1:  if (!m1_cyc_i) state_nxt = m0_cyc_i ? GRANT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_sel_o = 4'd0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    if (g0) begin
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i & ~to_ack;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (g1) begin
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i & ~to_ack;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  // The timeout ack replaces the slave response with all-ones data.
  assign m0_ack_o  = g0 & (s_ack_i | to_ack);
  assign m1_ack_o  = g1 & (s_ack_i | to_ack);
  assign m0_dat_o  = g0 ? (to_ack ? 32'hFFFF_FFFF : s_dat_i) : 32'd0;
  assign m1_dat_o  = g1 ? (to_ack ? 32'hFFFF_FFFF : s_dat_i) : 32'd0;
  assign m0_int_o  = s_int_i;
  assign m1_int_o  = s_int_i;
  assign timeout_o = to_ack;

  // A real ack in the last counted cycle suppresses the timeout.
  assign to_fire = (TIMEOUT != 0) && s_stb_o && !s_ack_i && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last   <= 1'b1;
      cnt    <= 16'd0;
      to_ack <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GRANT0)      last <= 1'b0;
      else if (state_nxt == GRANT1) last <= 1'b1;
      // A grant change restarts the wait so the new owner gets a full budget.
      if ((state_nxt != state) || !s_stb_o || s_ack_i) begin
        cnt    <= 16'd0;
        to_ack <= 1'b0;
      end else if (to_fire) begin
        cnt    <= 16'd0;
        to_ack <= 1'b1;
      end else begin
        if (TIMEOUT != 0) cnt <= cnt + 16'd1;
        to_ack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
module tb_wishbone_master_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] A0 = 32'hA000_0010;
  localparam logic [31:0] B0 = 32'hB000_0020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_we_i = 1'b0, m0_cyc_i = 1'b0, m0_stb_i = 1'b0;
  logic [3:0]  m0_sel_i = 4'd0;
  logic [31:0] m0_adr_i = 32'd0, m0_dat_i = 32'd0;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_int_o;
  logic        m1_we_i = 1'b0, m1_cyc_i = 1'b0, m1_stb_i = 1'b0;
  logic [3:0]  m1_sel_i = 4'd0;
  logic [31:0] m1_adr_i = 32'd0, m1_dat_i = 32'd0;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_int_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i = 32'd0;
  logic        s_ack_i = 1'b0, s_int_i = 1'b0;
  logic        timeout_o;

  int total_cnt = 0;
  int pass_cnt  = 0;

  wishbone_master_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_int_o(m0_int_o),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_int_o(m1_int_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_int_i(s_int_i),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
  endtask

  // Reference model: owner is -1 (nobody), 0 or 1; waited counts consecutive
  // strobed cycles without ack; tof marks the cycle carrying a timeout ack.
  int owner = -1;
  int lastg = 1;
  int waited = 0;
  bit tof = 1'b0;
  bit started = 1'b0;

  function automatic bit cyc_of(input int m);
    return (m == 0) ? m0_cyc_i : (m == 1) ? m1_cyc_i : 1'b0;
  endfunction

  function automatic bit stb_of(input int m);
    return (m == 0) ? m0_stb_i : (m == 1) ? m1_stb_i : 1'b0;
  endfunction

  always @(posedge clk) begin
    int  nown;
    bit  stb_vis;
    if (rst) begin
      owner  <= -1;
      lastg  <= 1;
      waited <= 0;
      tof    <= 1'b0;
    end else begin
      stb_vis = stb_of(owner) && !tof;
      if (owner < 0) begin
        if (m0_cyc_i && m1_cyc_i) nown = 1 - lastg;
        else if (m0_cyc_i)        nown = 0;
        else if (m1_cyc_i)        nown = 1;
        else                      nown = -1;
      end else if (cyc_of(owner)) nown = owner;
      else if (cyc_of(1 - owner)) nown = 1 - owner;
      else                        nown = -1;
      if (nown != owner || !stb_vis || s_ack_i) begin
        waited <= 0;
        tof    <= 1'b0;
      end else if (waited + 1 >= TO) begin
        waited <= 0;
        tof    <= 1'b1;
      end else begin
        waited <= waited + 1;
        tof    <= 1'b0;
      end
      if (nown >= 0) lastg <= nown;
      owner <= nown;
    end
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("s_cyc", s_cyc_o, owner >= 0 ? cyc_of(owner) : 1'b0);
      chk("s_stb", s_stb_o, stb_of(owner) && !tof);
      chk("s_we", s_we_o, owner == 0 ? m0_we_i : owner == 1 ? m1_we_i : 1'b0);
      chk("s_sel", s_sel_o, owner == 0 ? m0_sel_i : owner == 1 ? m1_sel_i : 4'd0);
      chk("s_adr", s_adr_o, owner == 0 ? m0_adr_i : owner == 1 ? m1_adr_i : 32'd0);
      chk("s_dat", s_dat_o, owner == 0 ? m0_dat_i : owner == 1 ? m1_dat_i : 32'd0);
      chk("m0_ack", m0_ack_o, owner == 0 && (s_ack_i || tof));
      chk("m1_ack", m1_ack_o, owner == 1 && (s_ack_i || tof));
      chk("m0_dat", m0_dat_o, owner == 0 ? (tof ? 32'hFFFF_FFFF : s_dat_i) : 32'd0);
      chk("m1_dat", m1_dat_o, owner == 1 ? (tof ? 32'hFFFF_FFFF : s_dat_i) : 32'd0);
      chk("m0_int", m0_int_o, s_int_i);
      chk("m1_int", m1_int_o, s_int_i);
      chk("timeout", timeout_o, tof);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    {m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i} = '0;
    m0_sel_i = 4'd0; m1_sel_i = 4'd0;
    m0_adr_i = 32'd0; m1_adr_i = 32'd0; m0_dat_i = 32'd0; m1_dat_i = 32'd0;
    s_ack_i = 1'b0; s_int_i = 1'b0; s_dat_i = 32'd0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_s_cyc", s_cyc_o, 1'b0);
    chk("rst_s_adr", s_adr_o, 32'd0);
    chk("rst_m0_ack", m0_ack_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);

    // m0 alone
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0100_0004;
    tick();
    s_ack_i = 1'b1; s_int_i = 1'b1;
    @(negedge clk);
    chk("m0_alone_adr", s_adr_o, 32'h0100_0004);
    chk("m0_alone_cyc", s_cyc_o, 1'b1);
    chk("m0_alone_ack0", m0_ack_o, 1'b1);
    chk("m0_alone_ack1", m1_ack_o, 1'b0);
    chk("int_g0_m0", m0_int_o, 1'b1);
    chk("int_g0_m1", m1_int_o, 1'b1);
    tick();
    clear_inputs();
    tick();

    // simultaneous after reset, round-robin, back-to-back
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = A0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = B0;
    tick();
    @(negedge clk);
    chk("tie_first_m0", s_adr_o, A0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    s_int_i = 1'b1;
    @(negedge clk);
    chk("handover_m1", s_adr_o, B0);
    chk("int_g1_m0", m0_int_o, 1'b1);
    chk("int_g1_m1", m1_int_o, 1'b1);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_int_i = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_cyc", s_cyc_o, 1'b0);
    chk("int_idle_lo", m1_int_o, 1'b0);
    s_int_i = 1'b1;
    #1;
    chk("int_idle_m0", m0_int_o, 1'b1);
    chk("int_idle_m1", m1_int_o, 1'b1);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    @(negedge clk);
    chk("tie_again_m0", s_adr_o, A0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    @(negedge clk);
    chk("b2b_m1", s_adr_o, B0);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    @(negedge clk);
    chk("b2b_hold_m1", s_adr_o, B0);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    @(negedge clk);
    chk("b2b_m0_adr", s_adr_o, A0);
    chk("b2b_m0_cyc", s_cyc_o, 1'b1);

    // timeout with TIMEOUT=8
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = A0;
    tick();
    repeat (7) tick();
    @(negedge clk);
    chk("to_c7_pulse", timeout_o, 1'b0);
    chk("to_c7_ack", m0_ack_o, 1'b0);
    tick();
    @(negedge clk);
    chk("to_c8_ack", m0_ack_o, 1'b1);
    chk("to_c8_dat", m0_dat_o, 32'hFFFF_FFFF);
    chk("to_c8_pulse", timeout_o, 1'b1);
    chk("to_c8_stb", s_stb_o, 1'b0);
    tick();
    @(negedge clk);
    chk("to_c9_pulse", timeout_o, 1'b0);
    chk("to_c9_stb", s_stb_o, 1'b1);
    repeat (7) tick();
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    @(negedge clk);
    chk("late_ack_ack", m0_ack_o, 1'b1);
    chk("late_ack_dat", m0_dat_o, 32'h1234_5678);
    chk("late_ack_pulse", timeout_o, 1'b0);
    tick();
    s_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack_after", timeout_o, 1'b0);

    // reset while m1 owns the bus
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = B0; m1_we_i = 1'b1;
    tick();
    @(negedge clk);
    chk("g1_before_rst", s_adr_o, B0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mid_cyc", s_cyc_o, 1'b0);
    chk("rst_mid_stb", s_stb_o, 1'b0);
    chk("rst_mid_adr", s_adr_o, 32'd0);
    chk("rst_mid_we", s_we_o, 1'b0);
    rst = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_tie", s_adr_o, A0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 7) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i & ($urandom_range(0, 5) != 0);
      m1_stb_i = m1_cyc_i & ($urandom_range(0, 5) != 0);
      m0_we_i  = $urandom_range(0, 1);
      m1_we_i  = $urandom_range(0, 1);
      m0_sel_i = 4'($urandom);
      m1_sel_i = 4'($urandom);
      m0_adr_i = $urandom; m1_adr_i = $urandom;
      m0_dat_i = $urandom; m1_dat_i = $urandom;
      s_dat_i  = $urandom;
      s_ack_i  = ($urandom_range(0, 11) == 0);
      s_int_i  = $urandom_range(0, 1);
    end

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
